ram_data_arbiter: RTL
=====================

Name: ram_data_arbiter

Overview:
- Shares the single data port of the RAM (dataAddr/inData/write_en/dataOut) between two requesters.
  - Master 0: CPU load/store unit.
  - Master 1: program loader / debug port.
- Each master uses a level req with a one-cycle ack pulse.
- The arbiter registers all RAM-side signals and sequences one access at a time.
- The RAM instruction port is untouched and stays wired directly to fetch.

Parameters:
- AW, 16, address width (matches RAM dataAddr).
- DW, 16, data width (matches RAM inData/dataOut).
- READ_LAT, 1, RAM data-read latency in clocks after the address edge; legal range 0..7.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request, level; held until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0, addr1  in  AW  word address; stable while req is high.
- wdata0, wdata1  in  DW  write data; stable while req is high.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  DW  read result; valid with ack, held until that master's next read completes.
- ram_addr  out  AW  to RAM dataAddr.
- ram_wdata  out  DW  to RAM inData.
- ram_we  out  1  to RAM write_en.
- ram_rdata  in  DW  from RAM dataOut.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = 1 (so master 0 wins the first tie).
- Reset takes effect asynchronously and drops ram_we at once. A write in ISSUE when reset asserts is not performed.
- States and transitions:
  - IDLE: if any req is high, pick a winner and go to ISSUE.
    - Sole requester wins.
    - Both requesting with FIXED_PRIO=1: master 0 wins.
    - Both requesting with FIXED_PRIO=0: winner is the master other than last_grant.
    - last_grant is updated to the winner.
    - The winner's addr/wdata/we are latched into ram_addr/ram_wdata/ram_we on the same edge.
  - ISSUE (1 cycle): RAM signals are driven. A write commits at the end of this cycle. ram_we is cleared on exit.
    - Write → DONE.
    - Read with READ_LAT = 0 → capture ram_rdata into rdata_winner at the end of ISSUE, then DONE.
    - Read with READ_LAT > 0 → WAIT, with wait_cnt = 0.
  - WAIT: ram_addr is held. wait_cnt increments each cycle.
    - When wait_cnt == READ_LAT-1: capture ram_rdata into rdata_winner, go to DONE.
  - DONE (1 cycle): ack_winner = 1, then IDLE.
- Latency, counting the cycle where req is first seen high in IDLE as cycle 0:
  - Write ack in cycle 2.
  - Read ack in cycle 2+READ_LAT.
  - Issue-to-issue spacing: 3 cycles (write), 3+READ_LAT cycles (read).
- Request hold and completion:
  - req/we/addr/wdata must hold until ack.
  - If req is still high in the cycle after ack, it is a new request.
  - Dropping req before ack does not abort the access; the ack still pulses.
- Losing requester waits; no starvation with FIXED_PRIO=0. With FIXED_PRIO=1, master 1 can starve (documented, not a bug).
- Only one ack is ever high in a given cycle. rdata of the non-winning master is never modified.
- Addresses pass through unmodified; no range checking.
- wait_cnt is 3 bits wide. READ_LAT > 7 is illegal and is flagged by an elaboration-time check.

Decomposition:
- Shared package ram_pkg:
  - state encoding IDLE/ISSUE/WAIT/DONE;
  - AW/DW defaults;
  - MAX_READ_LAT = 7.
- One natural sub-module: rr_arb2, a 2-way arbiter with last_grant state and a FIXED_PRIO option. It is combinational grant plus a registered pointer, reusable for future fetch/data arbitration.

Test Plan:
- Single write: req0, we0=1, addr0=10, wdata0=3 → ram_we=1 with ram_addr=10, ram_wdata=3 for exactly one cycle (cycle 1); ack0 pulses in cycle 2; a later read of 10 returns 3.
- Read latency sweep, for READ_LAT in {0, 1, 3}:
  - Preload 12←4; req1 reads 12 → ack1 in cycle 2+READ_LAT with rdata1=4.
  - rdata1 holds 4 afterwards while master 0 performs a write.
- Simultaneous requests, FIXED_PRIO=0, both req held continuously:
  - master 0 writes 14←5, master 1 writes 16←6;
  - grants alternate 0, 1, 0, 1;
  - acks never overlap; memory ends with 14=5, 16=6.
- FIXED_PRIO=1 with both req held for 4 accesses → master 0 gets all four; ack1 stays 0.
- Reset mid-operation: assert rst_n=0 during a write's ISSUE cycle (addr 10, data 9) → ram_we drops immediately; location 10 retains 3; all outputs 0; state IDLE; first post-reset tie goes to master 0.
- Early req drop: master 0 starts a read of 10, then drops req0 in WAIT → ack0 still pulses with rdata0=3; no new access is issued afterwards.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM data-port arbiter: FSM encoding and default widths.
package ram_pkg;
    localparam int AW_DEF       = 16;
    localparam int DW_DEF       = 16;
    localparam int MAX_READ_LAT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: combinational grant, registered last-grant pointer (reset favours master 0).
// No backpressure; the pointer only advances when update is asserted with a live request.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       any,
    output logic       winner
);
    logic last_grant;

    assign any = |req;

    always_comb begin
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end else if (req == 2'b11) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (update && any) begin
            last_grant <= winner;
        end
    end
endmodule

// File: rtl/ram_data_arbiter.sv
// Shares the RAM data port between two req/ack masters, one registered access at a time.
// Write acks 2 cycles after req is seen, reads 2+READ_LAT; losers simply hold req until served.
module ram_data_arbiter
    import ram_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);
    if (READ_LAT < 0 || READ_LAT > MAX_READ_LAT) begin : g_bad_read_lat
        $error("ram_data_arbiter: READ_LAT must be within 0..7");
    end

    localparam int          LW        = (READ_LAT > 0) ? READ_LAT - 1 : 0;
    localparam logic [2:0]  LAST_WAIT = LW[2:0];

    state_t     state, state_nxt;
    logic       win;
    logic [2:0] wait_cnt;
    logic       arb_any, arb_win;
    logic       rd_done;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .update (state == IDLE),
        .any    (arb_any),
        .winner (arb_win)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (ram_we) begin
                    state_nxt = DONE;
                end else if (READ_LAT == 0) begin
                    rd_done   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    rd_done   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ram_addr is left as-is after ISSUE so a pipelined RAM keeps seeing the read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= 1'b0;
            wait_cnt  <= 3'd0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
            if (state == IDLE && arb_any) begin
                win       <= arb_win;
                ram_addr  <= arb_win ? addr1  : addr0;
                ram_wdata <= arb_win ? wdata1 : wdata0;
                ram_we    <= arb_win ? we1    : we0;
            end
            if (state == ISSUE) begin
                ram_we <= 1'b0;
            end
            if (rd_done) begin
                if (win) rdata1 <= ram_rdata;
                else     rdata0 <= ram_rdata;
            end
            if (state_nxt == DONE) begin
                ack0 <= ~win;
                ack1 <= win;
            end
        end
    end
endmodule
